// File: rtl/car_state_ctrl.sv
// Driving-mode controller: power buttons and pedals in, one-hot car state out.
// Long-press power-on, immediate power-off, stall rules and idle auto-off.
module car_state_ctrl #(
    parameter int LONG_PRESS   = 100_000_000,
    parameter int IDLE_TIMEOUT = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic       power_off_btn,
    input  logic       throttle,
    input  logic       brake,
    input  logic       clutch,
    input  logic       reverse,
    output logic [3:0] state,
    output logic       reverse_mode
);

    typedef enum logic [3:0] {
        S_OFF          = 4'b0000,
        S_NOT_STARTING = 4'b0001,
        S_STARTING     = 4'b0010,
        S_MOVING       = 4'b0100
    } state_t;

    localparam int PW = (LONG_PRESS > 1) ? $clog2(LONG_PRESS) : 1;
    localparam logic [PW-1:0] PRESS_MAX = PW'(LONG_PRESS - 1);
    localparam logic [29:0]   IDLE_MAX  = 30'(IDLE_TIMEOUT - 1);

    logic [5:0]    r_sync1;
    logic [5:0]    r_sync2;
    state_t        r_state;
    logic          r_rev;
    logic [PW-1:0] r_press_cnt;
    logic [29:0]   r_idle_cnt;

    logic w_in_pwr;
    logic w_pwr_s;
    logic w_poff_s;
    logic w_thr_s;
    logic w_brake_s;
    logic w_clutch_s;
    logic w_rev_s;
    logic w_rev_diff;
    logic w_active;

    assign w_in_pwr   = power_btn;
    assign w_pwr_s    = r_sync2[5];
    assign w_poff_s   = r_sync2[4];
    assign w_thr_s    = r_sync2[3];
    assign w_brake_s  = r_sync2[2];
    assign w_clutch_s = r_sync2[1];
    assign w_rev_s    = r_sync2[0];
    assign w_rev_diff = w_rev_s != r_rev;
    assign w_active   = w_thr_s | w_brake_s | w_clutch_s | w_rev_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {w_in_pwr, power_off_btn, throttle, brake, clutch, reverse};
            r_sync2 <= r_sync1;
        end
    end

    // Counters default to clear; only the states that own them keep counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_OFF;
            r_rev       <= 1'b0;
            r_press_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_press_cnt <= '0;
            r_idle_cnt  <= '0;
            if (r_state == S_OFF)
                r_rev <= 1'b0;
            else if (r_state == S_MOVING && !w_clutch_s)
                r_rev <= r_rev;
            else
                r_rev <= w_rev_s;

            if (r_state != S_OFF && w_poff_s) begin
                r_state <= S_OFF;
            end else begin
                unique case (r_state)
                    S_OFF: begin
                        if (w_pwr_s && !w_poff_s) begin
                            if (r_press_cnt == PRESS_MAX)
                                r_state <= S_NOT_STARTING;
                            else
                                r_press_cnt <= r_press_cnt + PW'(1);
                        end
                    end
                    S_NOT_STARTING: begin
                        if (w_thr_s && !w_clutch_s)
                            r_state <= S_OFF;
                        else if (w_thr_s && w_clutch_s && !w_brake_s)
                            r_state <= S_STARTING;
                        else if (r_idle_cnt == IDLE_MAX)
                            r_state <= S_OFF;
                        else if (!w_active)
                            r_idle_cnt <= r_idle_cnt + 30'd1;
                    end
                    S_STARTING: begin
                        if (w_brake_s)
                            r_state <= S_NOT_STARTING;
                        else if (w_thr_s && !w_clutch_s)
                            r_state <= S_MOVING;
                    end
                    S_MOVING: begin
                        if (!w_clutch_s && w_rev_diff) begin
                            r_state <= S_OFF;
                            r_rev   <= 1'b0;
                        end else if (w_brake_s) begin
                            r_state <= S_NOT_STARTING;
                        end else if (w_clutch_s || !w_thr_s) begin
                            r_state <= S_STARTING;
                        end
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign state        = r_state;
    assign reverse_mode = r_rev;

endmodule

// File: tb/tb_car_state_ctrl.sv
// Directed bench for car_state_ctrl with LONG_PRESS=10, IDLE_TIMEOUT=50.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after.
module tb_car_state_ctrl;

    logic       clk;
    logic       rst;
    logic       power_btn;
    logic       power_off_btn;
    logic       throttle;
    logic       brake;
    logic       clutch;
    logic       reverse;
    logic [3:0] state;
    logic       reverse_mode;

    int n_checks;
    int n_fail;

    car_state_ctrl #(
        .LONG_PRESS  (10),
        .IDLE_TIMEOUT(50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .power_btn    (power_btn),
        .power_off_btn(power_off_btn),
        .throttle     (throttle),
        .brake        (brake),
        .clutch       (clutch),
        .reverse      (reverse),
        .state        (state),
        .reverse_mode (reverse_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Long press: state flips on the 12th edge after the input rises.
    task automatic power_on();
        power_btn = 1'b1;
        tick(11);
        chk("pon_early", state, 4'b0000);
        tick(1);
        chk("pon", state, 4'b0001);
        power_btn = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        power_btn = 1'b0;
        power_off_btn = 1'b0;
        throttle = 1'b0;
        brake = 1'b0;
        clutch = 1'b0;
        reverse = 1'b0;
        #12;
        chk("rst_state", state, 4'b0000);
        chk("rst_rev", {3'b0, reverse_mode}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // 9-cycle press is too short, then a full press
        power_btn = 1'b1;
        tick(9);
        power_btn = 1'b0;
        tick(5);
        chk("short_press", state, 4'b0000);
        power_on();
        tick(3);
        chk("hold_after_on", state, 4'b0001);

        // clutch+throttle -> STARTING -> MOVING -> STARTING -> NOT_STARTING
        clutch = 1'b1;
        tick(3);
        chk("clutch_only", state, 4'b0001);
        throttle = 1'b1;
        tick(2);
        chk("start_lat", state, 4'b0001);
        tick(1);
        chk("starting", state, 4'b0010);
        clutch = 1'b0;
        tick(2);
        chk("move_lat", state, 4'b0010);
        tick(1);
        chk("moving", state, 4'b0100);
        throttle = 1'b0;
        tick(3);
        chk("thr_rel", state, 4'b0010);
        brake = 1'b1;
        tick(3);
        chk("brake_ns", state, 4'b0001);
        brake = 1'b0;
        tick(3);

        // stall
        throttle = 1'b1;
        tick(2);
        chk("stall_lat", state, 4'b0001);
        tick(1);
        chk("stall", state, 4'b0000);
        throttle = 1'b0;

        // gear change without clutch
        power_on();
        clutch = 1'b1;
        throttle = 1'b1;
        tick(3);
        chk("rv_start", state, 4'b0010);
        clutch = 1'b0;
        tick(3);
        chk("rv_move", state, 4'b0100);
        reverse = 1'b1;
        tick(2);
        chk("rv_lat", state, 4'b0100);
        chk("rv_lat_mode", {3'b0, reverse_mode}, 4'b0000);
        tick(1);
        chk("rv_viol", state, 4'b0000);
        chk("rv_viol_mode", {3'b0, reverse_mode}, 4'b0000);
        throttle = 1'b0;
        reverse = 1'b0;

        // gear change with clutch
        power_on();
        clutch = 1'b1;
        throttle = 1'b1;
        tick(3);
        clutch = 1'b0;
        tick(3);
        chk("rc_move", state, 4'b0100);
        clutch = 1'b1;
        reverse = 1'b1;
        tick(3);
        chk("rc_state", state, 4'b0010);
        chk("rc_mode", {3'b0, reverse_mode}, 4'b0001);
        reverse = 1'b0;
        tick(3);
        chk("rc_mode_back", {3'b0, reverse_mode}, 4'b0000);
        power_off_btn = 1'b1;
        clutch = 1'b0;
        throttle = 1'b0;
        tick(3);
        chk("rc_off", state, 4'b0000);
        power_off_btn = 1'b0;
        tick(3);

        // idle timeout with no inputs
        power_on();
        tick(49);
        chk("idle_49", state, 4'b0001);
        tick(1);
        chk("idle_50", state, 4'b0000);

        // brake pulse at idle cycle 40 restarts the timeout
        power_on();
        tick(39);
        brake = 1'b1;
        tick(1);
        brake = 1'b0;
        tick(10);
        chk("idle_p50", state, 4'b0001);
        tick(41);
        chk("idle_p91", state, 4'b0001);
        tick(1);
        chk("idle_p92", state, 4'b0000);

        // async reset mid-MOVING in reverse
        power_on();
        clutch = 1'b1;
        throttle = 1'b1;
        reverse = 1'b1;
        tick(3);
        chk("ar_start", state, 4'b0010);
        chk("ar_start_mode", {3'b0, reverse_mode}, 4'b0001);
        clutch = 1'b0;
        tick(3);
        chk("ar_move", state, 4'b0100);
        chk("ar_move_mode", {3'b0, reverse_mode}, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_state", state, 4'b0000);
        chk("ar_mode", {3'b0, reverse_mode}, 4'b0000);
        throttle = 1'b0;
        reverse = 1'b0;
        #1;
        rst = 1'b0;
        tick(3);

        // power-off in STARTING, then both buttons together
        power_on();
        clutch = 1'b1;
        throttle = 1'b1;
        tick(3);
        clutch = 1'b0;
        throttle = 1'b0;
        tick(3);
        chk("po_starting", state, 4'b0010);
        power_off_btn = 1'b1;
        tick(2);
        chk("po_lat", state, 4'b0010);
        tick(1);
        chk("po_off", state, 4'b0000);
        power_btn = 1'b1;
        tick(15);
        chk("both_btn", state, 4'b0000);
        power_btn = 1'b0;
        power_off_btn = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/car_state_ctrl.md
# car_state_ctrl

Driving-mode controller for the little car. It turns the power buttons and pedal/gear inputs into the 4-bit car `state` that the segment display and motor stages consume: 0000 power off, 0100 moving. It also tracks the reverse gear. It handles long-press power-on, immediate power-off, stall rules and an idle auto-off timer.

## Interface
Parameters:
- `LONG_PRESS`, default 100_000_000: cycles `power_btn` must be held (synchronized) to power on; 1 s at 100 MHz.
- `IDLE_TIMEOUT`, default 1_000_000_000: inactivity cycles in NOT_STARTING before auto power-off; 10 s. Counter width is 30 bits.

Ports:
- `clk`  in  1  system clock, 100 MHz; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `power_btn`  in  1  power-on button, level.
- `power_off_btn`  in  1  power-off button, level.
- `throttle`  in  1  throttle pedal.
- `brake`  in  1  brake pedal.
- `clutch`  in  1  clutch pedal.
- `reverse`  in  1  reverse gear switch; 1 = reverse.
- `state`  out  4  car state: 0000 OFF, 0001 NOT_STARTING, 0010 STARTING, 0100 MOVING. No other value is ever driven.
- `reverse_mode`  out  1  latched gear; 1 = reverse.

## Operation
- All six inputs pass through a 2-flop synchronizer (suffix `_s` below); the FSM sees only synchronized values.
- Global rule: in any state other than OFF, `power_off_btn_s`=1 → OFF. This has the highest priority.
- OFF:
  - `press_cnt` increments each cycle `power_btn_s`=1 and clears when it is 0.
  - On the cycle `power_btn_s`=1 and `press_cnt`==LONG_PRESS-1 → NOT_STARTING and `press_cnt` clears.
  - `power_off_btn_s`=1 holds `press_cnt` at 0.
  - All pedals are ignored.
- NOT_STARTING, in priority order:
  - `throttle_s & ~clutch_s` → OFF (stall).
  - `throttle_s & clutch_s & ~brake_s` → STARTING.
  - `idle_cnt`==IDLE_TIMEOUT-1 → OFF.
- STARTING, in priority order:
  - `brake_s` → NOT_STARTING.
  - `throttle_s & ~clutch_s` → MOVING.
  - Otherwise stay.
- MOVING, in priority order:
  - `~clutch_s` and `reverse_s`≠`reverse_mode` → OFF (gear change without clutch).
  - `brake_s` → NOT_STARTING.
  - `clutch_s | ~throttle_s` → STARTING.
- `reverse_mode`:
  - Loads `reverse_s` every cycle, except in OFF (forced to 0) and in MOVING with `~clutch_s`, where it holds.
  - On the gear-change-without-clutch violation, the state goes OFF and `reverse_mode` clears on the same edge.
- `idle_cnt`:
  - Counts only in NOT_STARTING.
  - Clears on any state change, on any cycle with `throttle_s|brake_s|clutch_s`=1, or when `reverse_s`≠`reverse_mode`.
  - Never exceeds IDLE_TIMEOUT-1.

## Timing
- Reset values: `state`=0000, `reverse_mode`=0, both counters 0, all sync flops 0. Asynchronous assertion; the first update occurs on the first edge after release.
- Latency: an input stable before edge k is visible as `_s` after edge k+1. A resulting `state` change appears after edge k+2. Outputs come straight from registers, with no combinational path from inputs.
- Power-on: `state` becomes 0001 on the edge where the `LONG_PRESS`-th consecutive synchronized high cycle is sampled. A release of even one synchronized cycle restarts the count.
- Idle: `state` becomes 0000 on the `IDLE_TIMEOUT`-th consecutive idle cycle in NOT_STARTING.
- Simultaneous events: the priority lists above are exhaustive. Example: in MOVING with brake + clutch, the result is NOT_STARTING.
- Reset mid-operation (any state, any counter value): outputs return to reset values immediately, asynchronously.
- Holding `power_btn` after power-on has no effect. `power_btn` and `power_off_btn` held together: `power_off_btn` wins, so the car stays or goes OFF.

## Test plan
Bench parameters: LONG_PRESS=10, IDLE_TIMEOUT=50.

- Reset, then hold `power_btn` 9 synchronized cycles and release → `state` stays 0000. Hold again for 12 cycles → `state`=0001 exactly 10 synchronized cycles (12 clk from input rise) after press.
- From 0001: clutch=1, then throttle=1 → 0010. Release clutch → 0100. Release throttle → 0010. Brake=1 → 0001.
- From 0001: throttle=1 with clutch=0 → 0000 after 3 edges.
- In 0100: toggle `reverse` with clutch=0 → `state`=0000 and `reverse_mode`=0. Repeat with clutch=1 → `reverse_mode` follows the switch and `state` goes 0010 (clutch rule).
- In 0001 with no inputs → 0000 after exactly 50 idle cycles. Pulse brake at cycle 40 → timeout restarts and off occurs 50 cycles after the brake release is synchronized.
- Assert `rst` mid-MOVING with `reverse_mode`=1 → `state`=0000 and `reverse_mode`=0 with no clock edge. Assert `power_off_btn` in 0010 → 0000.
